// File: rtl/grid_px_writer_pkg.sv
// Shared video parameters for the tile-grid painter: screen geometry, tile grid,
// FSM state encoding and the tile index helper.
package grid_px_writer_pkg;

    localparam int DEF_AW       = 15;
    localparam int DEF_DW       = 3;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam int TILE_COLS = 4;
    localparam int TILE_ROWS = 2;
    localparam int NUM_TILES = TILE_COLS * TILE_ROWS;
    localparam int COL_BITS  = 2;
    localparam int ROW_BITS  = 1;
    localparam int TILE_BITS = COL_BITS + ROW_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PAINT = 2'd2,
        DONE  = 2'd3
    } px_state_e;

    // Tile number is row*TILE_COLS + col; with 4 columns that is a plain concat.
    function automatic logic [TILE_BITS-1:0] tileIndex(input logic [ROW_BITS-1:0] rowIdx,
                                                       input logic [COL_BITS-1:0] colIdx);
        return {rowIdx, colIdx};
    endfunction

endpackage

// File: rtl/grid_px_writer_if.sv
// Bundle between the game logic, the tile painter and the frame buffer:
// live tile colours in, frame-buffer write port and status out.
interface grid_px_writer_if
    import grid_px_writer_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();

    logic [DW-1:0] cuadroColores0;
    logic [DW-1:0] cuadroColores1;
    logic [DW-1:0] cuadroColores2;
    logic [DW-1:0] cuadroColores3;
    logic [DW-1:0] cuadroColores4;
    logic [DW-1:0] cuadroColores5;
    logic [DW-1:0] cuadroColores6;
    logic [DW-1:0] cuadroColores7;

    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;
    logic          busy;
    logic          frame_done;

    modport master (
        input  cuadroColores0, cuadroColores1, cuadroColores2, cuadroColores3,
        input  cuadroColores4, cuadroColores5, cuadroColores6, cuadroColores7,
        output mem_px_addr, mem_px_data, px_wr, busy, frame_done
    );

    modport slave (
        output cuadroColores0, cuadroColores1, cuadroColores2, cuadroColores3,
        output cuadroColores4, cuadroColores5, cuadroColores6, cuadroColores7,
        input  mem_px_addr, mem_px_data, px_wr, busy, frame_done
    );

endinterface

// File: rtl/grid_px_writer_px_scan_counter.sv
// Raster scan counter: x/y/linear address plus tile column/row counters that
// advance on tile boundaries, so tile lookup needs no division.
module px_scan_counter
    import grid_px_writer_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int AW       = DEF_AW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       step,
    output logic [$clog2(SCREEN_W)-1:0] x,
    output logic [$clog2(SCREEN_H)-1:0] y,
    output logic [AW-1:0]               addr,
    output logic [TILE_BITS-1:0]        tile_idx,
    output logic                        last,
    output logic [TILE_BITS-1:0]        next_tile
);

    localparam int TILE_W = SCREEN_W / TILE_COLS;
    localparam int TILE_H = SCREEN_H / TILE_ROWS;
    localparam int XW     = $clog2(SCREEN_W);
    localparam int YW     = $clog2(SCREEN_H);
    localparam int TXW    = $clog2(TILE_W);
    localparam int TYW    = $clog2(TILE_H);

    localparam logic [XW-1:0]  X_LAST  = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0]  Y_LAST  = YW'(SCREEN_H - 1);
    localparam logic [TXW-1:0] TX_LAST = TXW'(TILE_W - 1);
    localparam logic [TYW-1:0] TY_LAST = TYW'(TILE_H - 1);

    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [TXW-1:0]      tx_q, tx_d;
    logic [TYW-1:0]      ty_q, ty_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic                lastPix;

    assign lastPix = (x_q == X_LAST) && (y_q == Y_LAST);

    // Position after one step; the final pixel holds so the address never overruns.
    always_comb begin
        x_d    = x_q + 1'b1;
        y_d    = y_q;
        addr_d = addr_q + 1'b1;
        tx_d   = tx_q + 1'b1;
        ty_d   = ty_q;
        col_d  = col_q;
        row_d  = row_q;
        if (tx_q == TX_LAST) begin
            tx_d  = '0;
            col_d = col_q + 1'b1;
        end
        if (x_q == X_LAST) begin
            x_d   = '0;
            tx_d  = '0;
            col_d = '0;
            y_d   = y_q + 1'b1;
            ty_d  = ty_q + 1'b1;
            if (ty_q == TY_LAST) begin
                ty_d  = '0;
                row_d = row_q + 1'b1;
            end
        end
        if (lastPix) begin
            x_d    = x_q;
            y_d    = y_q;
            addr_d = addr_q;
            tx_d   = tx_q;
            ty_d   = ty_q;
            col_d  = col_q;
            row_d  = row_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
            tx_q   <= '0;
            ty_q   <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else if (step) begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
            tx_q   <= tx_d;
            ty_q   <= ty_d;
            col_q  <= col_d;
            row_q  <= row_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign addr      = addr_q;
    assign last      = lastPix;
    assign tile_idx  = tileIndex(row_q, col_q);
    assign next_tile = tileIndex(row_d, col_d);

endmodule

// File: rtl/grid_px_writer.sv
// Repaints the whole frame buffer as a 4x2 grid of solid tiles whenever any live
// tile colour differs from the snapshot of the last repaint (or after reset).
module grid_px_writer
    import grid_px_writer_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic               clk,
    input  logic               rst,
    grid_px_writer_if.master   bus
);

    px_state_e            state_q;
    logic                 init_q;
    logic [DW-1:0]        shadow_q [NUM_TILES];
    logic                 pxWr_q;
    logic                 busy_q;
    logic                 frameDone_q;
    logic [DW-1:0]        pxData_q;

    logic [DW-1:0]        live [NUM_TILES];
    logic                 changed;
    logic                 scanClr;
    logic                 scanStep;
    logic                 scanLast;
    logic [AW-1:0]        scanAddr;
    logic [TILE_BITS-1:0] scanTile;
    logic [TILE_BITS-1:0] scanNextTile;
    logic [$clog2(SCREEN_W)-1:0] scanX;
    logic [$clog2(SCREEN_H)-1:0] scanY;
    logic                 unusedScan;

    always_comb begin
        live[0] = bus.cuadroColores0;
        live[1] = bus.cuadroColores1;
        live[2] = bus.cuadroColores2;
        live[3] = bus.cuadroColores3;
        live[4] = bus.cuadroColores4;
        live[5] = bus.cuadroColores5;
        live[6] = bus.cuadroColores6;
        live[7] = bus.cuadroColores7;
    end

    always_comb begin
        changed = 1'b0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (live[i] != shadow_q[i]) changed = 1'b1;
        end
    end

    assign scanClr  = (state_q == LOAD);
    assign scanStep = (state_q == PAINT) && !scanLast;

    px_scan_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .AW       (AW)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .clr       (scanClr),
        .step      (scanStep),
        .x         (scanX),
        .y         (scanY),
        .addr      (scanAddr),
        .tile_idx  (scanTile),
        .last      (scanLast),
        .next_tile (scanNextTile)
    );

    assign unusedScan = ^{scanX, scanY, scanTile};

    // Data is loaded one pixel ahead so it lines up with the scan address register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            init_q      <= 1'b1;
            pxWr_q      <= 1'b0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
            pxData_q    <= '0;
            for (int i = 0; i < NUM_TILES; i++) shadow_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pxWr_q      <= 1'b0;
                    frameDone_q <= 1'b0;
                    if (init_q || changed) begin
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    shadow_q <= live;
                    init_q   <= 1'b0;
                    pxWr_q   <= 1'b1;
                    pxData_q <= live[0];
                    state_q  <= PAINT;
                end
                PAINT: begin
                    if (scanLast) begin
                        pxWr_q      <= 1'b0;
                        busy_q      <= 1'b0;
                        frameDone_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        pxData_q <= shadow_q[scanNextTile];
                    end
                end
                DONE: begin
                    frameDone_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_px_addr = scanAddr;
    assign bus.mem_px_data = pxData_q;
    assign bus.px_wr       = pxWr_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frameDone_q;

endmodule
